// File: rtl/data_mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store access unit.
package data_mem_access_pkg;

  // Register write modes handed to the WB-stage load extender
  localparam logic [2:0] RW_NOREGWRITE = 3'd0;
  localparam logic [2:0] RW_LB         = 3'd1;
  localparam logic [2:0] RW_LH         = 3'd2;
  localparam logic [2:0] RW_LW         = 3'd3;
  localparam logic [2:0] RW_LBU        = 3'd4;
  localparam logic [2:0] RW_LHU        = 3'd5;
  localparam logic [2:0] RW_ALU        = 3'd6;

  // Store types
  localparam logic [1:0] MW_SNONE = 2'd0;
  localparam logic [1:0] MW_SB    = 2'd1;
  localparam logic [1:0] MW_SH    = 2'd2;
  localparam logic [1:0] MW_SW    = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True when the write mode is one of the load codes
  function automatic logic is_load_code(input logic [2:0] rw);
    logic res;
    case (rw)
      RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_access_lane_steer.sv
// Store byte-lane steering and alignment check for loads and stores.
module data_mem_access_lane_steer
  import data_mem_access_pkg::*;
(
  input  logic [1:0]  i_mem_write,
  input  logic [2:0]  i_reg_write,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  // Lane enables / replicated data for stores; misalignment for stores or (store-less) loads
  always_comb begin
    o_we       = 4'b0000;
    o_wdata    = 32'h0000_0000;
    o_misalign = 1'b0;
    case (i_mem_write)
      MW_SB: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      MW_SH: begin
        o_wdata = {2{i_store_data[15:0]}};
        if (i_addr_lo[0]) begin
          o_misalign = 1'b1;
        end else begin
          o_we = 4'b0011 << i_addr_lo;
        end
      end
      MW_SW: begin
        o_wdata = i_store_data;
        if (i_addr_lo != 2'b00) begin
          o_misalign = 1'b1;
        end else begin
          o_we = 4'b1111;
        end
      end
      default: begin
        case (i_reg_write)
          RW_LH, RW_LHU: o_misalign = i_addr_lo[0];
          RW_LW:         o_misalign = (i_addr_lo != 2'b00);
          default:       o_misalign = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage load/store access unit: memory handshake FSM, timeout, MEM/WB payload register.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid_m,
  input  logic [2:0]  i_reg_write_m,
  input  logic [1:0]  i_mem_write_m,
  input  logic [31:0] i_alu_out_m,
  input  logic [31:0] i_store_data_m,
  output logic        o_stall_mem,
  output logic        o_dmem_req,
  output logic [29:0] o_dmem_addr,
  output logic [3:0]  o_dmem_we,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid_w,
  output logic [31:0] o_rdata_w,
  output logic [1:0]  o_loaded_bytes_select_w,
  output logic [2:0]  o_reg_write_w,
  output logic        o_misalign_w,
  output logic        o_bus_err_w
);

  state_e      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_valid_w;
  logic [31:0] r_rdata_w;
  logic [1:0]  r_lbs_w;
  logic [2:0]  r_reg_write_w;
  logic        r_misalign_w;
  logic        r_bus_err_w;

  logic        w_is_store;
  logic        w_is_load;
  logic        w_mem_op;
  logic        w_lane_misalign;
  logic        w_misalign_op;
  logic        w_access;
  logic        w_timeout;
  logic [3:0]  w_lane_we;
  logic [31:0] w_lane_wdata;
  logic [2:0]  w_commit_rw;
  logic [31:0] w_commit_rdata;
  logic        w_req;
  logic        w_stall;

  data_mem_access_lane_steer u_lane_steer (
    .i_mem_write  (i_mem_write_m),
    .i_reg_write  (i_reg_write_m),
    .i_addr_lo    (i_alu_out_m[1:0]),
    .i_store_data (i_store_data_m),
    .o_we         (w_lane_we),
    .o_wdata      (w_lane_wdata),
    .o_misalign   (w_lane_misalign)
  );

  // A store code overrides any load code present in the same instruction
  assign w_is_store     = (i_mem_write_m != MW_SNONE);
  assign w_is_load      = is_load_code(i_reg_write_m) & ~w_is_store;
  assign w_mem_op       = i_valid_m & (w_is_store | is_load_code(i_reg_write_m));
  assign w_misalign_op  = w_mem_op & w_lane_misalign;
  assign w_access       = w_mem_op & ~w_lane_misalign;
  assign w_timeout      = (r_state == ST_WAIT) && (r_wait_cnt == 8'(MAX_WAIT));
  assign w_commit_rw    = w_is_store ? RW_NOREGWRITE : i_reg_write_m;
  assign w_commit_rdata = w_is_load ? i_dmem_rdata : i_alu_out_m;

  // Request and stall: the abort cycle releases the stall so the pipe can advance
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req   = w_access;
        w_stall = w_access & ~i_dmem_ack;
      end
      ST_WAIT: begin
        w_req   = 1'b1;
        w_stall = ~i_dmem_ack & ~w_timeout;
      end
      default: begin
        w_req   = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  assign o_stall_mem  = w_stall;
  assign o_dmem_req   = w_req;
  assign o_dmem_addr  = i_alu_out_m[31:2];
  assign o_dmem_we    = w_access ? w_lane_we : 4'b0000;
  assign o_dmem_wdata = w_lane_wdata;

  // Handshake FSM, wait counter and MEM/WB payload register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= 8'd0;
      r_valid_w     <= 1'b0;
      r_rdata_w     <= 32'h0000_0000;
      r_lbs_w       <= 2'b00;
      r_reg_write_w <= RW_NOREGWRITE;
      r_misalign_w  <= 1'b0;
      r_bus_err_w   <= 1'b0;
    end else begin
      r_valid_w     <= 1'b0;
      r_rdata_w     <= 32'h0000_0000;
      r_lbs_w       <= 2'b00;
      r_reg_write_w <= RW_NOREGWRITE;
      r_misalign_w  <= 1'b0;
      r_bus_err_w   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (i_dmem_ack) begin
              r_valid_w     <= 1'b1;
              r_rdata_w     <= w_commit_rdata;
              r_lbs_w       <= i_alu_out_m[1:0];
              r_reg_write_w <= w_commit_rw;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= 8'd1;
            end
          end else if (w_misalign_op) begin
            r_valid_w    <= 1'b1;
            r_rdata_w    <= i_alu_out_m;
            r_lbs_w      <= i_alu_out_m[1:0];
            r_misalign_w <= 1'b1;
          end else if (i_valid_m) begin
            r_valid_w     <= 1'b1;
            r_rdata_w     <= i_alu_out_m;
            r_lbs_w       <= i_alu_out_m[1:0];
            r_reg_write_w <= i_reg_write_m;
          end else begin
            r_valid_w <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_dmem_ack) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= 8'd0;
            r_valid_w     <= 1'b1;
            r_rdata_w     <= w_commit_rdata;
            r_lbs_w       <= i_alu_out_m[1:0];
            r_reg_write_w <= w_commit_rw;
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 8'd0;
            r_valid_w   <= 1'b1;
            r_lbs_w     <= i_alu_out_m[1:0];
            r_bus_err_w <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign o_valid_w               = r_valid_w;
  assign o_rdata_w               = r_rdata_w;
  assign o_loaded_bytes_select_w = r_lbs_w;
  assign o_reg_write_w           = r_reg_write_w;
  assign o_misalign_w            = r_misalign_w;
  assign o_bus_err_w             = r_bus_err_w;

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: vector table plus hand-built multi-cycle sequences,
// with a scoreboard queue of expected WB payloads.
module tb_data_mem_access;

  localparam logic [2:0] NOREG = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5, ALU = 3'd6;
  localparam logic [1:0] SNONE = 2'd0, SB = 2'd1, SH = 2'd2, SW = 2'd3;

  typedef struct {
    logic        chk_data;
    logic [31:0] rdata;
    logic [1:0]  lbs;
    logic [2:0]  rw;
    logic        mis;
    logic        berr;
  } wexp_t;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [2:0]  rw;
    logic [1:0]  mw;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        ack;
    logic [31:0] rdata;
    logic        chk_ctl;
    logic        req;
    logic        stall;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exp_w;
    wexp_t       w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m;
  logic [2:0]  reg_write_m;
  logic [1:0]  mem_write_m;
  logic [31:0] alu_out_m;
  logic [31:0] store_data_m;
  logic        stall_mem;
  logic        dmem_req;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_w;
  logic [31:0] rdata_w;
  logic [1:0]  lbs_w;
  logic [2:0]  reg_write_w;
  logic        misalign_w;
  logic        bus_err_w;

  int    n_checks = 0;
  int    n_fail   = 0;
  wexp_t sbq[$];
  wexp_t w_none;
  vec_t  tv[12];
  vec_t  v;

  always #5 clk = ~clk;

  data_mem_access #(.MAX_WAIT(4)) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_valid_m               (valid_m),
    .i_reg_write_m           (reg_write_m),
    .i_mem_write_m           (mem_write_m),
    .i_alu_out_m             (alu_out_m),
    .i_store_data_m          (store_data_m),
    .o_stall_mem             (stall_mem),
    .o_dmem_req              (dmem_req),
    .o_dmem_addr             (dmem_addr),
    .o_dmem_we               (dmem_we),
    .o_dmem_wdata            (dmem_wdata),
    .i_dmem_ack              (dmem_ack),
    .i_dmem_rdata            (dmem_rdata),
    .o_valid_w               (valid_w),
    .o_rdata_w               (rdata_w),
    .o_loaded_bytes_select_w (lbs_w),
    .o_reg_write_w           (reg_write_w),
    .o_misalign_w            (misalign_w),
    .o_bus_err_w             (bus_err_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic wexp_t wx(input logic cd, input logic [31:0] rd, input logic [1:0] lbs,
                               input logic [2:0] rw, input logic mis, input logic berr);
    wexp_t r;
    r.chk_data = cd; r.rdata = rd; r.lbs = lbs; r.rw = rw; r.mis = mis; r.berr = berr;
    return r;
  endfunction

  function automatic vec_t mk(input logic valid, input logic [2:0] rw, input logic [1:0] mw,
                              input logic [31:0] addr, input logic [31:0] sd, input logic ack,
                              input logic [31:0] rdata, input logic req, input logic stall,
                              input logic [3:0] we, input logic [31:0] wdata,
                              input logic exp_w, input wexp_t w);
    vec_t r;
    r.rst_n = 1'b1; r.valid = valid; r.rw = rw; r.mw = mw; r.addr = addr; r.sd = sd;
    r.ack = ack; r.rdata = rdata; r.chk_ctl = 1'b1; r.req = req; r.stall = stall;
    r.we = we; r.wdata = wdata; r.exp_w = exp_w; r.w = w;
    return r;
  endfunction

  // Drive one cycle of inputs, queue its expected payload, check the combinational outputs
  task automatic apply(input vec_t vv, input string nm);
    @(posedge clk);
    #1;
    rst_n        = vv.rst_n;
    valid_m      = vv.valid;
    reg_write_m  = vv.rw;
    mem_write_m  = vv.mw;
    alu_out_m    = vv.addr;
    store_data_m = vv.sd;
    dmem_ack     = vv.ack;
    dmem_rdata   = vv.rdata;
    if (vv.exp_w) sbq.push_back(vv.w);
    @(negedge clk);
    if (vv.chk_ctl) begin
      chk({nm, "_req"}, {31'd0, dmem_req}, {31'd0, vv.req});
      chk({nm, "_stall"}, {31'd0, stall_mem}, {31'd0, vv.stall});
      chk({nm, "_we"}, {28'd0, dmem_we}, {28'd0, vv.we});
      if (vv.we != 4'b0000) chk({nm, "_wdata"}, dmem_wdata, vv.wdata);
      if (vv.req) chk({nm, "_addr"}, {2'b00, dmem_addr}, vv.addr >> 2);
    end
  endtask

  // Scoreboard: every WB payload must match the oldest queued expectation
  always @(negedge clk) begin
    if (valid_w === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid_w", {31'd0, valid_w}, 32'd0);
      end else begin
        wexp_t e;
        e = sbq.pop_front();
        chk("w_reg_write", {29'd0, reg_write_w}, {29'd0, e.rw});
        chk("w_misalign", {31'd0, misalign_w}, {31'd0, e.mis});
        chk("w_bus_err", {31'd0, bus_err_w}, {31'd0, e.berr});
        if (e.chk_data) begin
          chk("w_rdata", rdata_w, e.rdata);
          chk("w_lbs", {30'd0, lbs_w}, {30'd0, e.lbs});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    w_none = wx(1'b0, 32'h0, 2'd0, NOREG, 1'b0, 1'b0);
    rst_n = 1'b0; valid_m = 1'b0; reg_write_m = NOREG; mem_write_m = SNONE;
    alu_out_m = 32'h0; store_data_m = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_w", {31'd0, valid_w}, 32'd0);
    chk("rst_reg_write_w", {29'd0, reg_write_w}, 32'd0);
    chk("rst_misalign_w", {31'd0, misalign_w}, 32'd0);
    chk("rst_bus_err_w", {31'd0, bus_err_w}, 32'd0);
    chk("rst_rdata_w", rdata_w, 32'd0);
    chk("rst_lbs_w", {30'd0, lbs_w}, 32'd0);

    // Single-cycle vectors: same-cycle ack, misaligned, pass-through, bubble
    tv[0]  = mk(1, LW, SNONE, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1, 0, 4'b0000, 32'h0,
                1, wx(1, 32'hDEADBEEF, 2'd0, LW, 0, 0));
    tv[1]  = mk(1, NOREG, SB, 32'h202, 32'h000000A5, 1, 32'h0, 1, 0, 4'b0100, 32'hA5A5A5A5,
                1, wx(1, 32'h202, 2'd2, NOREG, 0, 0));
    tv[2]  = mk(1, NOREG, SH, 32'h202, 32'h1234BEEF, 1, 32'h0, 1, 0, 4'b1100, 32'hBEEFBEEF,
                1, wx(1, 32'h202, 2'd2, NOREG, 0, 0));
    tv[3]  = mk(1, NOREG, SW, 32'h204, 32'h11223344, 1, 32'h0, 1, 0, 4'b1111, 32'h11223344,
                1, wx(1, 32'h204, 2'd0, NOREG, 0, 0));
    tv[4]  = mk(1, NOREG, SB, 32'h203, 32'h0000005A, 1, 32'h0, 1, 0, 4'b1000, 32'h5A5A5A5A,
                1, wx(1, 32'h203, 2'd3, NOREG, 0, 0));
    tv[5]  = mk(1, LH, SNONE, 32'h301, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0,
                1, wx(0, 32'h0, 2'd0, NOREG, 1, 0));
    tv[6]  = mk(1, NOREG, SW, 32'h302, 32'hFFFFFFFF, 0, 32'h0, 0, 0, 4'b0000, 32'h0,
                1, wx(0, 32'h0, 2'd0, NOREG, 1, 0));
    tv[7]  = mk(1, ALU, SNONE, 32'hCAFEF00D, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0,
                1, wx(1, 32'hCAFEF00D, 2'd1, ALU, 0, 0));
    tv[8]  = mk(0, LW, SNONE, 32'h100, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 0, w_none);
    tv[9]  = mk(1, LB, SB, 32'h401, 32'h00000077, 1, 32'h99999999, 1, 0, 4'b0010, 32'h77777777,
                1, wx(1, 32'h401, 2'd1, NOREG, 0, 0));
    tv[10] = mk(1, LHU, SNONE, 32'h502, 32'h0, 1, 32'h80001234, 1, 0, 4'b0000, 32'h0,
                1, wx(1, 32'h80001234, 2'd2, LHU, 0, 0));
    tv[11] = mk(1, LH, SNONE, 32'h500, 32'h0, 1, 32'h0000FFFE, 1, 0, 4'b0000, 32'h0,
                1, wx(1, 32'h0000FFFE, 2'd0, LH, 0, 0));
    for (int i = 0; i < 12; i++) apply(tv[i], $sformatf("v%0d", i));

    // LBU 0x103 acked after three stalled cycles; address held at word 0x40
    v = mk(1, LBU, SNONE, 32'h103, 32'h0, 0, 32'h0, 1, 1, 4'b0000, 32'h0, 0, w_none);
    for (int i = 0; i < 3; i++) apply(v, $sformatf("lbu_wait%0d", i));
    v = mk(1, LBU, SNONE, 32'h103, 32'h0, 1, 32'h11223344, 1, 0, 4'b0000, 32'h0,
           1, wx(1, 32'h11223344, 2'd3, LBU, 0, 0));
    apply(v, "lbu_ack");

    // LW never acked: four stalled cycles, then abort with the stall released
    v = mk(1, LW, SNONE, 32'h600, 32'h0, 0, 32'h0, 1, 1, 4'b0000, 32'h0, 0, w_none);
    for (int i = 0; i < 4; i++) apply(v, $sformatf("to_wait%0d", i));
    v = mk(1, LW, SNONE, 32'h600, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0,
           1, wx(0, 32'h0, 2'd0, NOREG, 0, 1));
    v.chk_ctl = 1'b0;
    apply(v, "to_abort");
    chk("to_abort_stall", {31'd0, stall_mem}, 32'd0);
    // Late ack in IDLE: no request, no payload
    v = mk(0, NOREG, SNONE, 32'h0, 32'h0, 1, 32'h12345678, 0, 0, 4'b0000, 32'h0, 0, w_none);
    apply(v, "late_ack");
    v.ack = 1'b0;
    apply(v, "after_late_ack");

    // Reset while waiting: request and stall drop, no payload committed
    v = mk(1, LW, SNONE, 32'h700, 32'h0, 0, 32'h0, 1, 1, 4'b0000, 32'h0, 0, w_none);
    apply(v, "rw_wait0");
    apply(v, "rw_wait1");
    v.rst_n = 1'b0;
    v.chk_ctl = 1'b0;
    apply(v, "rw_reset");
    v = mk(0, NOREG, SNONE, 32'h0, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 0, w_none);
    apply(v, "rw_after");
    chk("rw_after_valid_w", {31'd0, valid_w}, 32'd0);
    v = mk(1, LW, SNONE, 32'h100, 32'h0, 1, 32'h0BADF00D, 1, 0, 4'b0000, 32'h0,
           1, wx(1, 32'h0BADF00D, 2'd0, LW, 0, 0));
    apply(v, "rw_recover");

    // Flush and confirm every expected payload appeared
    v = mk(0, NOREG, SNONE, 32'h0, 32'h0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 0, w_none);
    apply(v, "flush0");
    apply(v, "flush1");
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
